// File: rtl/line_session_ctrl.sv
// Line-oriented UART session controller: gathers a terminated line, issues one
// request to the compute engine, then streams the response (or an error reply).
module line_session_ctrl #(
  parameter int         MAX_IN   = 32,
  parameter int         MAX_OUT  = 8,
  parameter logic [7:0] TERM     = 8'h0A,
  parameter bit         STRIP_CR = 1'b1,
  parameter logic [7:0] ERR_BYTE = 8'h45,
  localparam int        CW       = $clog2(MAX_IN + 1),
  localparam int        OW       = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_vld,
  input  logic [7:0]           rx_data,
  output logic                 tx_ready,
  output logic [7:0]           tx_data,
  input  logic                 tx_rd,
  output logic                 req_valid,
  output logic [MAX_IN*8-1:0]  req_data,
  output logic [CW-1:0]        req_len,
  input  logic                 req_ready,
  input  logic                 resp_valid,
  input  logic [MAX_OUT*8-1:0] resp_data,
  input  logic [OW-1:0]        resp_len,
  output logic                 resp_ready,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [2:0] {
    ST_RX,
    ST_DISCARD,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_ERR
  } state_t;

  state_t               state_reg;
  logic [CW-1:0]        count_reg;
  logic [7:0]           line_mem [MAX_IN];
  logic [MAX_OUT*8-1:0] out_buf_reg;
  logic [OW-1:0]        idx_reg;
  logic [OW-1:0]        len_reg;
  logic [OW-1:0]        idx_next;
  logic [7:0]           cur_byte;
  logic                 last_byte;
  logic                 drop_state;

  for (genvar gi = 0; gi < MAX_IN; gi++) begin : g_pack
    assign req_data[(MAX_IN-1-gi)*8 +: 8] = line_mem[gi];
  end

  assign req_len    = count_reg;
  assign busy       = (state_reg != ST_RX);
  assign resp_ready = (state_reg == ST_WAIT);
  assign drop_state = (state_reg != ST_RX) && (state_reg != ST_DISCARD);
  assign idx_next   = idx_reg + OW'(1);

  // ERR reuses the SEND handshake with a fixed two-byte reply.
  assign last_byte = (state_reg == ST_ERR) ? (idx_reg != '0) : (idx_next == len_reg);

  always_comb begin
    cur_byte = '0;
    if (state_reg == ST_ERR) begin
      cur_byte = (idx_reg == '0) ? ERR_BYTE : TERM;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (idx_reg == OW'(i)) cur_byte = out_buf_reg[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_RX;
      count_reg   <= '0;
      for (int i = 0; i < MAX_IN; i++) line_mem[i] <= '0;
      out_buf_reg <= '0;
      idx_reg     <= '0;
      len_reg     <= '0;
      req_valid   <= 1'b0;
      tx_ready    <= 1'b0;
      tx_data     <= '0;
      drop_cnt    <= '0;
    end else begin
      if (rx_vld && drop_state && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      case (state_reg)
        ST_RX: begin
          if (rx_vld && !(STRIP_CR && rx_data == 8'h0D)) begin
            if (rx_data == TERM) begin
              if (count_reg != '0) begin
                state_reg <= ST_REQ;
                req_valid <= 1'b1;
              end
            end else if (count_reg != CW'(MAX_IN)) begin
              for (int i = 0; i < MAX_IN; i++) begin
                if (count_reg == CW'(i)) line_mem[i] <= rx_data;
              end
              count_reg <= count_reg + CW'(1);
            end else begin
              state_reg <= ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (rx_vld && rx_data == TERM) begin
            state_reg <= ST_ERR;
            idx_reg   <= '0;
            count_reg <= '0;
            for (int i = 0; i < MAX_IN; i++) line_mem[i] <= '0;
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            out_buf_reg <= resp_data;
            len_reg     <= (resp_len > OW'(MAX_OUT)) ? OW'(MAX_OUT) : resp_len;
            idx_reg     <= '0;
            count_reg   <= '0;
            for (int i = 0; i < MAX_IN; i++) line_mem[i] <= '0;
            state_reg   <= (resp_len == '0) ? ST_RX : ST_SEND;
          end
        end
        ST_SEND, ST_ERR: begin
          // A gap cycle with tx_ready low separates every consumed byte.
          if (!tx_ready) begin
            tx_ready <= 1'b1;
            tx_data  <= cur_byte;
          end else if (tx_rd) begin
            tx_ready <= 1'b0;
            idx_reg  <= idx_next;
            if (last_byte) state_reg <= ST_RX;
          end
        end
        default: state_reg <= ST_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_line_session_ctrl.sv
// Directed bench for line_session_ctrl: a vector table of whole lines plus
// hand-written sequences for overflow, request stall, and mid-transfer reset.
module tb_line_session_ctrl;

  localparam int MAX_IN  = 32;
  localparam int MAX_OUT = 8;
  localparam int CW      = 6;
  localparam int OW      = 4;
  localparam int NV      = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 rx_vld = 1'b0;
  logic [7:0]           rx_data = '0;
  logic                 tx_ready;
  logic [7:0]           tx_data;
  logic                 tx_rd = 1'b0;
  logic                 req_valid;
  logic [MAX_IN*8-1:0]  req_data;
  logic [CW-1:0]        req_len;
  logic                 req_ready = 1'b0;
  logic                 resp_valid = 1'b0;
  logic [MAX_OUT*8-1:0] resp_data = '0;
  logic [OW-1:0]        resp_len = '0;
  logic                 resp_ready;
  logic                 busy;
  logic [15:0]          drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          n_in;
    logic [63:0] in_bytes;
    bit          exp_req;
    int          exp_len;
    logic [63:0] exp_top;
    int          rlen;
    logic [63:0] rdata;
    int          exp_tx_n;
    logic [63:0] exp_tx;
  } vec_t;

  vec_t vecs [NV];

  line_session_ctrl #(
    .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .TERM(8'h0A), .STRIP_CR(1'b1), .ERR_BYTE(8'h45)
  ) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_rd(tx_rd),
    .req_valid(req_valid), .req_data(req_data), .req_len(req_len), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_len(resp_len), .resp_ready(resp_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_data = b;
    step();
    rx_vld  = 1'b0;
  endtask

  task automatic wait_tx();
    int t = 0;
    while (!tx_ready && t < 20) begin
      step();
      t++;
    end
    chk("tx_ready_wait", 256'(tx_ready), 256'(1));
  endtask

  // Accept the pending request, then deliver a response of rlen bytes.
  task automatic engine(input int rlen, input logic [63:0] rdata);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("req_valid_drop", 256'(req_valid), 256'(0));
    chk("resp_ready", 256'(resp_ready), 256'(1));
    resp_valid = 1'b1;
    resp_len   = OW'(rlen);
    resp_data  = rdata;
    step();
    resp_valid = 1'b0;
  endtask

  // Expect n bytes (byte k in bits k*8+:8), then an idle controller.
  task automatic collect_tx(input string tag, input int n, input logic [63:0] bytes);
    logic [63:0] b;
    b = bytes;
    for (int k = 0; k < n; k++) begin
      wait_tx();
      chk("tx_data", 256'(tx_data), 256'(b[k*8 +: 8]));
      tx_rd = 1'b1;
      step();
      tx_rd = 1'b0;
      chk("tx_ready_drop", 256'(tx_ready), 256'(0));
    end
    chk("busy_after_tx", 256'(busy), 256'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_extra_tx", 256'(tx_ready), 256'(0));
    end
    $display("%s: %0d bytes transmitted, drop_cnt=%0d", tag, n, drop_cnt);
  endtask

  initial begin
    logic [63:0] line;
    logic [255:0] exp_wide;

    vecs[0] = '{5, 64'h31322B330A000000, 1'b1, 4, 64'h31322B3300000000, 2, 64'h3531, 2, 64'h3531};
    vecs[1] = '{3, 64'h370D0A0000000000, 1'b1, 1, 64'h3700000000000000, 1, 64'h41, 1, 64'h41};
    vecs[2] = '{1, 64'h0A00000000000000, 1'b0, 0, 64'h0, 0, 64'h0, 0, 64'h0};
    vecs[3] = '{3, 64'h61620A0000000000, 1'b1, 2, 64'h6162000000000000, 12, 64'h0807060504030201, 8, 64'h0807060504030201};
    vecs[4] = '{2, 64'h780A000000000000, 1'b1, 1, 64'h7800000000000000, 0, 64'hFF, 0, 64'h0};
    vecs[5] = '{5, 64'h0D0D390D0A000000, 1'b1, 1, 64'h3900000000000000, 3, 64'hCCBBAA, 3, 64'hCCBBAA};

    // Reset values
    #12;
    chk("rst_tx_ready", 256'(tx_ready), 256'(0));
    chk("rst_tx_data", 256'(tx_data), 256'(0));
    chk("rst_req_valid", 256'(req_valid), 256'(0));
    chk("rst_req_data", req_data, 256'(0));
    chk("rst_req_len", 256'(req_len), 256'(0));
    chk("rst_resp_ready", 256'(resp_ready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_drop_cnt", 256'(drop_cnt), 256'(0));
    step();
    rst = 1'b1;
    step();

    // Request stalled for 10 cycles with three strobes dropped meanwhile
    send_byte(8'h35);
    send_byte(8'h0A);
    chk("stall_req_valid", 256'(req_valid), 256'(1));
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 4 || c == 6) begin
        rx_vld  = 1'b1;
        rx_data = (c == 4) ? 8'h0A : 8'h5A;
      end
      step();
      rx_vld = 1'b0;
      chk("stall_req_valid", 256'(req_valid), 256'(1));
      chk("stall_req_data", req_data, {8'h35, 248'b0});
      chk("stall_req_len", 256'(req_len), 256'(1));
    end
    chk("stall_drop_cnt", 256'(drop_cnt), 256'(3));
    engine(0, 64'h0);
    chk("stall_busy_len0", 256'(busy), 256'(0));
    send_byte(8'h38);
    send_byte(8'h0A);
    chk("after_stall_req_valid", 256'(req_valid), 256'(1));
    chk("after_stall_req_len", 256'(req_len), 256'(1));
    chk("after_stall_req_data", req_data, {8'h38, 248'b0});
    engine(1, 64'h39);
    collect_tx("stall line", 1, 64'h39);

    // Vector table
    for (int v = 0; v < NV; v++) begin
      line = vecs[v].in_bytes;
      for (int b = 0; b < vecs[v].n_in; b++) begin
        send_byte(line[63-8*b -: 8]);
        if (b < vecs[v].n_in - 1) chk("req_valid_early", 256'(req_valid), 256'(0));
      end
      chk("req_valid", 256'(req_valid), 256'(vecs[v].exp_req));
      if (vecs[v].exp_req) begin
        chk("req_len", 256'(req_len), 256'(vecs[v].exp_len));
        chk("req_data", req_data, {vecs[v].exp_top, 192'b0});
        chk("busy_req", 256'(busy), 256'(1));
        engine(vecs[v].rlen, vecs[v].rdata);
        collect_tx($sformatf("vec %0d req_len=%0d resp_len=%0d", v, req_len, vecs[v].rlen),
                   vecs[v].exp_tx_n, vecs[v].exp_tx);
      end else begin
        for (int k = 0; k < 3; k++) begin
          step();
          chk("empty_no_req", 256'(req_valid), 256'(0));
          chk("empty_busy", 256'(busy), 256'(0));
        end
        $display("vec %0d: empty line, no request", v);
      end
    end

    // Exactly MAX_IN bytes is a legal line
    for (int i = 0; i < 32; i++) send_byte(8'h40 + 8'(i));
    chk("full_no_req_yet", 256'(req_valid), 256'(0));
    send_byte(8'h0A);
    exp_wide = 256'h404142434445464748494A4B4C4D4E4F505152535455565758595A5B5C5D5E5F;
    chk("full_req_valid", 256'(req_valid), 256'(1));
    chk("full_req_len", 256'(req_len), 256'(32));
    chk("full_req_data", req_data, exp_wide);
    engine(0, 64'h0);
    chk("full_busy", 256'(busy), 256'(0));
    $display("full line: req_len=32 accepted");

    // One byte too many: discard, error reply, then a normal line
    for (int i = 0; i < 33; i++) send_byte(8'h41);
    chk("ovf_busy", 256'(busy), 256'(1));
    chk("ovf_no_req", 256'(req_valid), 256'(0));
    send_byte(8'h0A);
    chk("ovf_no_req_term", 256'(req_valid), 256'(0));
    collect_tx("overflow error reply", 2, 64'h0A45);
    send_byte(8'h31);
    send_byte(8'h0A);
    chk("post_ovf_req_valid", 256'(req_valid), 256'(1));
    chk("post_ovf_req_len", 256'(req_len), 256'(1));
    chk("post_ovf_req_data", req_data, {8'h31, 248'b0});
    engine(0, 64'h0);

    // Reset mid-line
    send_byte(8'h39);
    chk("midline_len", 256'(req_len), 256'(1));
    #2 rst = 1'b0;
    #1;
    chk("midline_rst_len", 256'(req_len), 256'(0));
    chk("midline_rst_data", req_data, 256'(0));
    step();
    rst = 1'b1;
    step();

    // Reset while byte 2 of 4 is offered
    send_byte(8'h34);
    send_byte(8'h0A);
    engine(4, 64'h44332211);
    wait_tx();
    chk("midtx_byte0", 256'(tx_data), 256'(8'h11));
    tx_rd = 1'b1;
    step();
    tx_rd = 1'b0;
    wait_tx();
    chk("midtx_byte1", 256'(tx_data), 256'(8'h22));
    #2 rst = 1'b0;
    #1;
    chk("midtx_rst_tx_ready", 256'(tx_ready), 256'(0));
    chk("midtx_rst_tx_data", 256'(tx_data), 256'(0));
    chk("midtx_rst_busy", 256'(busy), 256'(0));
    chk("midtx_rst_drop_cnt", 256'(drop_cnt), 256'(0));
    chk("midtx_rst_req_valid", 256'(req_valid), 256'(0));
    step();
    step();
    rst = 1'b1;
    step();
    send_byte(8'h36);
    send_byte(8'h0A);
    chk("post_rst_req_len", 256'(req_len), 256'(1));
    chk("post_rst_req_data", req_data, {8'h36, 248'b0});
    engine(2, 64'hBBAA);
    collect_tx("post-reset line", 2, 64'hBBAA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_session_ctrl.md
Name: line_session_ctrl

Overview:
- Parametrised line-oriented UART session controller for the calculator datapath.
- Collects received bytes into a line buffer of up to MAX_IN bytes until a terminator arrives, then issues one packed request to a compute engine over a valid/ready handshake.
- Waits for a variable-length byte-string response and streams it to the UART writer one byte at a time.
- Adds the following: overflow detection with an error reply, empty-line suppression, optional CR stripping, and counting of bytes dropped while busy.

Parameters:
- MAX_IN, 32, line buffer depth in bytes (≥2).
- MAX_OUT, 8, maximum response length in bytes (≥1).
- TERM, 8'h0A, line terminator byte.
- STRIP_CR, 1, when 1, received 8'h0D bytes are discarded silently.
- ERR_BYTE, 8'h45, byte sent, followed by TERM, on line overflow.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rx_vld  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  out  1  request to UART writer; tx_data valid while high
- tx_data  out  8  byte to transmit
- tx_rd  in  1  writer strobe: current byte consumed
- req_valid  out  1  request to compute engine
- req_data  out  MAX_IN*8  packed line; first byte in bits [MAX_IN*8-1 -: 8]
- req_len  out  $clog2(MAX_IN+1)  payload byte count, terminator excluded
- req_ready  in  1  engine accepts request
- resp_valid  in  1  engine result valid
- resp_data  in  MAX_OUT*8  result; first byte to send in bits [7:0]
- resp_len  in  $clog2(MAX_OUT+1)  result byte count
- resp_ready  out  1  controller accepts result
- busy  out  1  high in any state except RX
- drop_cnt  out  16  saturating count of rx_vld strobes ignored outside RX/DISCARD

Behaviour:
- Reset (rst=0, asynchronous): state RX. All outputs are 0, the buffer count is 0, drop_cnt is 0, and buffer contents are 0.
- RX state, on rx_vld:
  - If the byte is 8'h0D and STRIP_CR=1, ignore it.
  - If the byte is TERM and count=0, ignore it (empty line: no request).
  - If the byte is TERM and count>0, go to REQ next cycle.
  - Otherwise, if count<MAX_IN, store the byte at index count and increment count.
  - Otherwise (count==MAX_IN), go to DISCARD.
- DISCARD: accept and drop bytes until TERM, then go to ERR. No request is issued.
- REQ:
  - req_valid rises on the cycle after the terminator is accepted.
  - req_data holds the stored bytes, left-aligned, with unused low bytes 0. req_len equals count.
  - req_data and req_len are stable while req_valid is high.
  - On req_valid&&req_ready: drop req_valid and go to WAIT_RESP.
- WAIT_RESP:
  - resp_ready is high.
  - On resp_valid: latch resp_data and len=min(resp_len, MAX_OUT), clear the line buffer and count, and go to SEND.
  - If the latched len=0, go directly to RX.
- SEND:
  - Drive tx_data with byte[idx] (bits idx*8 +: 8) and hold tx_ready high until tx_rd is sampled high.
  - On tx_rd: tx_ready is 0 for at least one cycle and idx increments.
  - When idx==len after the increment, go to RX. Otherwise present the next byte.
- ERR: send ERR_BYTE then TERM using the SEND handshake, clear the buffer, and return to RX.
- rx_vld while busy:
  - Outside RX/DISCARD the byte is ignored and drop_cnt increments, saturating at 16'hFFFF.
  - A byte arriving on the same cycle as the return to RX is accepted (the state is RX on that edge).
- tx_rd while tx_ready=0 is ignored. resp_valid outside WAIT_RESP is ignored (resp_ready=0).
- Reset asserted mid-line, mid-request or mid-transmit: immediate return to reset values. No partial byte or request is retained.
- Counters never wrap: idx ranges over 0..MAX_OUT and count over 0..MAX_IN.

Test Plan:
1. Line "12+3\n" with MAX_IN=32: req_valid rises 1 cycle after '\n'; req_len=4; req_data top 32 bits=32'h31322B33, rest 0. Engine returns resp_len=2, resp_data[15:0]=16'h3531: tx sends 8'h31 then 8'h35, then state RX.
2. Line "7\r\n" with STRIP_CR=1: req_len=1, req_data top byte 8'h37. A bare "\n" issues no request (req_valid stays 0).
3. 33 non-terminator bytes then '\n' (MAX_IN=32): no req_valid; tx sends 8'h45 then 8'h0A; the next line "1\n" produces a normal request with req_len=1.
4. Hold req_ready=0 for 10 cycles: req_valid/req_data stable; 3 rx_vld strobes in that window give drop_cnt=3 and leave the next request unaffected.
5. resp_len=12 with MAX_OUT=8: exactly 8 bytes are sent. resp_len=0: no tx_ready, immediate return to RX.
6. rst=0 while tx_ready=1 on byte 2 of 4: all outputs 0 asynchronously; after release, a fresh line is processed normally and tx_data starts at byte 0.
